// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path: receiver state
// encoding, default frame geometry and counter-width helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_e;

    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_OVERSAMPLE = 16;

    // Width of a counter that must hold 0..n-1 (never less than one bit).
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_TICK_W = cnt_w(DEF_OVERSAMPLE);
    localparam int DEF_BIT_W  = cnt_w(DEF_DATA_BITS);

endpackage

// File: rtl/uart_rx_core_if.sv
// Host-side interface of the UART receiver: received word, status pulses and,
// when UART_RX_PARITY_EN is defined, the parity select and parity error pulse.
interface uart_rx_core_if #(
    parameter int DATA_BITS = uart_pkg::DEF_DATA_BITS
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 busy;
`ifdef UART_RX_PARITY_EN
    logic                 parity_odd;
    logic                 parity_err;

    modport master (output rx_data, rx_valid, frame_err, busy, parity_err, input parity_odd);
    modport slave  (input rx_data, rx_valid, frame_err, busy, parity_err, output parity_odd);
`else
    modport master (output rx_data, rx_valid, frame_err, busy);
    modport slave  (input rx_data, rx_valid, frame_err, busy);
`endif
endinterface

// File: rtl/uart_rx_sync.sv
// Brings the asynchronous serial line into the clock domain and turns each
// rising edge of the baud oversample clock into a one-cycle tick.
module uart_rx_sync (
    input  logic clock,
    input  logic reset_n,
    input  logic baud_clk,
    input  logic rx_in,
    output logic rx_s,
    output logic tick
);
    logic rx_meta_q, rx_meta_d;
    logic rx_sync_q, rx_sync_d;
    logic baud_q, baud_d;
    logic baud_qq, baud_qd;

    always_comb begin
        rx_meta_d = rx_in;
        rx_sync_d = rx_meta_q;
        baud_d    = baud_clk;
        baud_qd   = baud_q;
    end

    // Line flops reset to the idle (high) level so reset never looks like a start bit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            baud_q    <= 1'b0;
            baud_qq   <= 1'b0;
        end else begin
            rx_meta_q <= rx_meta_d;
            rx_sync_q <= rx_sync_d;
            baud_q    <= baud_d;
            baud_qq   <= baud_qd;
        end
    end

    assign rx_s = rx_sync_q;
    assign tick = baud_q & ~baud_qq;

endmodule

// File: rtl/uart_rx_core.sv
// UART receive engine: start validation, LSB-first data capture, stop check.
// Optional parity checking is compiled in with UART_RX_PARITY_EN.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic clock,
    input  logic reset_n,
    input  logic baud_clk,
    input  logic rx_in,
    uart_rx_core_if.master host
);
    localparam int TICK_W = cnt_w(OVERSAMPLE);
    localparam int BIT_W  = cnt_w(DATA_BITS);
    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

    logic rx_s, tick;

    state_e                state_q, state_d;
    logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]      bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic                  par_bit_q, par_bit_d;
    logic                  parity_err_q, parity_err_d;
`endif

    uart_rx_sync u_sync (
        .clock    (clock),
        .reset_n  (reset_n),
        .baud_clk (baud_clk),
        .rx_in    (rx_in),
        .rx_s     (rx_s),
        .tick     (tick)
    );

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d    = par_bit_q;
        parity_err_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d    = START;
                    tick_cnt_d = '0;
                end
            end
            START: begin
                // Re-check the line half a bit in; a high sample was a glitch.
                if (tick) begin
                    if (tick_cnt_q == HALF_LAST) begin
                        tick_cnt_d = '0;
                        bit_idx_d  = '0;
                        state_d    = rx_s ? IDLE : DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tick_cnt_q == FULL_LAST) begin
                        tick_cnt_d = '0;
                        shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
                        if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bit_idx_d = bit_idx_q + 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (tick_cnt_q == FULL_LAST) begin
                        tick_cnt_d = '0;
                        par_bit_d  = rx_s;
                        state_d    = STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (tick_cnt_q == FULL_LAST) begin
                        tick_cnt_d = '0;
                        if (rx_s) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                            state_d    = IDLE;
`ifdef UART_RX_PARITY_EN
                            parity_err_d = ((^shift_q) ^ par_bit_q) != host.parity_odd;
`endif
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = BREAK;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            BREAK: begin
                // Hold off until the line returns high so a stuck-low line cannot retrigger.
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= par_bit_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign host.rx_data   = rx_data_q;
    assign host.rx_valid  = rx_valid_q;
    assign host.frame_err = frame_err_q;
    assign host.busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign host.parity_err = parity_err_q;
`endif

endmodule
